// File: rtl/edge_detector_mc.sv
// rtl/edge_detector_mc.sv - multi-channel hit edge detector with dead-time, timestamps and missed counts
module edge_detector_mc #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 16,
  parameter int DEAD_W      = 8,
  parameter int MW          = 8
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [N_CH-1:0]      iHit,
  input  logic [2*N_CH-1:0]    iMode,
  input  logic [DEAD_W-1:0]    iDead,
  input  logic                 iClrMissed,
  output logic [N_CH-1:0]      oRise,
  output logic [N_CH-1:0]      oFall,
  output logic [N_CH-1:0]      oEvent,
  output logic [CW*N_CH-1:0]   oStamp,
  output logic [CW-1:0]        oCoarse,
  output logic [MW*N_CH-1:0]   oMissed
);

  logic [CW-1:0] r_coarse;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) r_coarse <= '0;
    else       r_coarse <= r_coarse + 1'b1;
  end

  assign oCoarse = r_coarse;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_q;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_event;
    logic [DEAD_W-1:0]      r_dt;
    logic [CW-1:0]          r_stamp;
    logic [MW-1:0]          r_missed;
    logic                   w_sync_last;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_qual;

    assign w_sync_last = r_sync[SYNC_STAGES-1];
    assign w_rise      = w_sync_last & ~r_q;
    assign w_fall      = ~w_sync_last & r_q;
    assign w_qual      = (iMode[2*c] & w_rise) | (iMode[2*c+1] & w_fall);

    always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
        r_sync   <= '0;
        r_q      <= 1'b0;
        r_rise   <= 1'b0;
        r_fall   <= 1'b0;
        r_event  <= 1'b0;
        r_dt     <= '0;
        r_stamp  <= '0;
        r_missed <= '0;
      end else begin
        r_sync  <= {r_sync[SYNC_STAGES-2:0], iHit[c]};
        r_q     <= w_sync_last;
        r_rise  <= w_rise;
        r_fall  <= w_fall;
        r_event <= w_qual && (r_dt == '0);

        // Dead-time keeps counting down through suppressed edges, so it is a pure cycle count.
        if (w_qual && (r_dt == '0)) begin
          r_dt    <= iDead;
          r_stamp <= r_coarse;
        end else if (r_dt != '0) begin
          r_dt <= r_dt - 1'b1;
        end

        if (iClrMissed)
          r_missed <= '0;
        else if (w_qual && (r_dt != '0) && (r_missed != '1))
          r_missed <= r_missed + 1'b1;
      end
    end

    assign oRise[c]            = r_rise;
    assign oFall[c]            = r_fall;
    assign oEvent[c]           = r_event;
    assign oStamp[CW*c +: CW]  = r_stamp;
    assign oMissed[MW*c +: MW] = r_missed;
  end

endmodule

// File: doc/edge_detector_mc.md
# edge_detector_mc

Multi-channel, parametrised edge detector for the TDC hit front end. It synchronises N_CH asynchronous hit lines into the iClk domain and reports raw rising and falling edges per channel. It also produces a mode-qualified event pulse, with a programmable per-channel dead-time, a coarse timestamp latched on each event, and a saturating count of edges suppressed by dead-time. It sits between the hit input pins and the fine-time/readout logic, replacing the single-channel Edge block.

## Interface
- N_CH, 4, number of hit channels
- SYNC_STAGES, 2, synchroniser flops per channel (must be >= 2)
- CW, 16, coarse counter / timestamp width
- DEAD_W, 8, dead-time counter width
- MW, 8, missed-event counter width per channel
- iClk  in  1  system clock, all logic on rising edge
- iRst  in  1  asynchronous, active-low reset; all registers cleared while low
- iHit  in  N_CH  asynchronous hit inputs
- iMode  in  2*N_CH  per channel [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both
- iDead  in  DEAD_W  dead-time in cycles, shared by all channels
- iClrMissed  in  1  synchronous clear of all oMissed counters
- oRise  out  N_CH  one-cycle pulse per synchronised rising edge (mode-independent)
- oFall  out  N_CH  one-cycle pulse per synchronised falling edge (mode-independent)
- oEvent  out  N_CH  one-cycle pulse per accepted, mode-qualified edge
- oStamp  out  CW*N_CH  per-channel timestamp of last accepted event, field [CW*c +: CW]
- oCoarse  out  CW  free-running coarse counter
- oMissed  out  MW*N_CH  per-channel saturating count of suppressed edges, field [MW*c +: MW]

## Operation
- Per channel: SYNC_STAGES-flop chain on iHit[c], then a previous-value register q. rise = sync_last & ~q; fall = ~sync_last & q.
- oRise/oFall are registered and high for exactly one cycle per edge.
- qualified = (mode[0] & rise) | (mode[1] & fall). Mode 00 gives no events and no missed counts.
- Dead-time counter dt[c] (DEAD_W bits):
  - qualified & dt==0: oEvent pulses, dt loads iDead, and oStamp field loads the current (pre-increment) coarse count.
  - qualified & dt!=0: no oEvent; oMissed[c] increments, saturating at 2^MW-1.
  - Otherwise dt decrements toward 0.
- iDead=0 means no dead-time. iDead is sampled only when dt loads.
- Coarse counter increments every cycle and wraps modulo 2^CW. oStamp wraps with it; there is no overflow flag.
- iClrMissed clears every oMissed the next cycle and wins over a simultaneous increment.
- iMode changes apply to edges detected in the same cycle as the new value. A mode change does not alter dt.
- Channels are fully independent; simultaneous edges on all channels are each processed in the same cycle.

## Timing
- Reset values: oRise, oFall, oEvent, oStamp, oMissed, oCoarse = 0. Sync chains, q and dt = 0.
- Reset is asynchronous: mid-operation assertion clears all state immediately, and no pulse completes.
- iHit level at reset release is compared against q=0, so a high input is reported as one rising edge.
- Latency: an iHit transition first captured at edge 0 gives oRise/oFall/oEvent high from edge SYNC_STAGES to edge SYNC_STAGES+1 (3rd cycle for default).
- oStamp is valid in the same cycle as oEvent, holds until the next accepted event, and equals oCoarse-1 (mod 2^CW) during that cycle.
- After an event in cycle t with iDead=D, the earliest next event is in cycle t+D+1.
- Pulses narrower than one iClk period may be missed; this is by design.

## Test plan
- Basic edges: reset, mode 11 on ch0, iHit[0] 0->1 at edge 0, 1->0 at edge 10 -> oRise[0] high in cycle after edge 2 only, oFall[0] after edge 12, oEvent[0] both times, other channels silent.
- Modes: ch0..3 modes 00/01/10/11, same 0->1->0 pulse on all -> oRise/oFall on all four; oEvent ch1 rise only, ch2 fall only, ch3 both, ch0 never; oMissed all 0.
- Dead-time: iDead=5, mode 11, toggle iHit[0] every 2 cycles for 20 cycles -> oEvent spacing >= 6 cycles, oMissed[0] = edges minus events; then pulse iClrMissed -> 0 next cycle.
- Saturation: MW=8, iDead=255, 300 qualified edges in dead-time -> oMissed[0]=255 and stays there; iClrMissed coincident with an edge -> 0.
- Timestamp wrap: CW=4, edges at coarse 14 and 18 (wrapped) -> oStamp[0] = 14 then 2, each equal to oCoarse-1 mod 16 in the event cycle.
- Reset: iHit[1]=1 held through reset release -> one oRise[1]/oEvent[1] (mode 01) at cycle 3; assert iRst mid dead-time -> all outputs 0 immediately, dt cleared.
